// File: rtl/ax_lfsr_decider_if.sv
// Request/decision bundle between the fetch front-end and ax_lfsr_decider.
interface ax_lfsr_decider_if #(
    parameter int LANES       = 4,
    parameter int LEVEL_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
);
    logic                   levelWe;
    logic [LEVEL_WIDTH-1:0] levelIn;
    logic                   reseedReq;
    logic [LANES-1:0]       reqValid;
    logic                   stall;
    logic                   cntClear;
    logic                   ready;
    logic [LANES-1:0]       decValid;
    logic [LANES-1:0]       decApprox;
    logic [LEVEL_WIDTH-1:0] level;
    logic [CNT_WIDTH-1:0]   approxCount;

    modport master (
        output levelWe, levelIn, reseedReq, reqValid, stall, cntClear,
        input  ready, decValid, decApprox, level, approxCount
    );

    modport slave (
        input  levelWe, levelIn, reseedReq, reqValid, stall, cntClear,
        output ready, decValid, decApprox, level, approxCount
    );
endinterface

// File: rtl/ax_lfsr_decider.sv
// Per-lane approximation decider: compares LFSR slices against the programmed
// level, registers one decision per lane with 1-cycle latency, and keeps a
// saturating count of approximated instructions.
module ax_lfsr_decider #(
    parameter int                    LANES       = 4,
    parameter int                    LEVEL_WIDTH = 5,
    parameter int                    LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = 32'h1010,
    parameter logic [LFSR_WIDTH-1:0] TAP_MASK    = 32'h80200003,
    parameter int                    CNT_WIDTH   = 16
) (
    input logic              clk,
    input logic              rstN,
    ax_lfsr_decider_if.slave bus
);

    localparam int                   SUM_W   = CNT_WIDTH + $clog2(LANES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN,
        RESEED
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   run_ok;
    logic                   ready;
    logic                   accept_p0;
    logic [LANES-1:0]       approx_p0;
    logic [LFSR_WIDTH-1:0]  lfsr;
    logic [LFSR_WIDTH-1:0]  lfsr_adv;
    logic [LFSR_WIDTH-1:0]  lfsr_next;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic [LANES-1:0]       vld_p1;
    logic [LANES-1:0]       approx_p1;
    logic [CNT_WIDTH-1:0]   cnt;

    // One Galois step: shift right, fold the mask in when a one drops out.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur);
        logic [LFSR_WIDTH-1:0] nxt;
        nxt = (cur >> 1) ^ (cur[0] ? TAP_MASK : '0);
        return nxt;
    endfunction

    // Counter plus popcount of new approximations, clamped at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                     input logic [LANES-1:0]     bits);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base);
        for (int i = 0; i < LANES; i++) begin
            sum = sum + SUM_W'(bits[i]);
        end
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    // ready is held low until the first clock after reset release.
    assign ready = run_ok && (state == RUN);

    // Per-lane decision from the pre-advance LFSR state; a zero level never matches.
    always_comb begin
        approx_p0 = '0;
        for (int i = 0; i < LANES; i++) begin
            approx_p0[i] = bus.reqValid[i] && (lfsr[i*LEVEL_WIDTH +: LEVEL_WIDTH] < level_q);
        end
    end

    // Next LFSR value with lock-up guard (a zero state would never leave zero).
    always_comb begin
        lfsr_adv  = lfsr_step(lfsr);
        lfsr_next = (lfsr_adv == '0) ? LFSR_SEED : lfsr_adv;
    end

    // FSM next state and accept; a reseed request in the same cycle drops the request.
    always_comb begin
        state_next = state;
        accept_p0  = 1'b0;
        case (state)
            RUN: begin
                accept_p0 = ready && !bus.stall && !bus.reseedReq && (|bus.reqValid);
                if (ready && !bus.stall && bus.reseedReq) begin
                    state_next = RESEED;
                end
            end
            RESEED: begin
                if (!bus.stall) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // FSM state register and the post-reset ready qualifier.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= RUN;
            run_ok <= 1'b0;
        end else begin
            state  <= state_next;
            run_ok <= 1'b1;
        end
    end

    // Level register; loads even while stalled.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            level_q <= '0;
        end else if (bus.levelWe) begin
            level_q <= bus.levelIn;
        end
    end

    // LFSR: reload in RESEED, advance once per accepted request, hold otherwise.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lfsr <= LFSR_SEED;
        end else if (!bus.stall) begin
            if (state == RESEED) begin
                lfsr <= LFSR_SEED;
            end else if (accept_p0) begin
                lfsr <= lfsr_next;
            end
        end
    end

    // Decision register stage p0 -> p1; stall freezes both valid and decision.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vld_p1    <= '0;
            approx_p1 <= '0;
        end else if (!bus.stall) begin
            vld_p1 <= accept_p0 ? bus.reqValid : '0;
            if (accept_p0) begin
                approx_p1 <= approx_p0;
            end
        end
    end

    // Statistics counter; clear wins over the same-edge increment.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt <= '0;
        end else if (bus.cntClear) begin
            cnt <= '0;
        end else if (!bus.stall && accept_p0) begin
            cnt <= sat_add(cnt, approx_p0);
        end
    end

    lfsr_never_zero: assert property (@(posedge clk) disable iff (!rstN)
        accept_p0 |-> (lfsr_adv != '0));

    assign bus.ready       = ready;
    assign bus.decValid    = vld_p1;
    assign bus.decApprox   = approx_p1;
    assign bus.level       = level_q;
    assign bus.approxCount = cnt;

endmodule

// File: tb/tb_ax_lfsr_decider.sv
// Directed bench for ax_lfsr_decider with a reference model feeding a scoreboard.
module tb_ax_lfsr_decider;

    localparam logic [31:0] SEED = 32'h1010;
    localparam logic [31:0] MASK = 32'h80200003;

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  approx;
        logic [3:0]  cnt;
        logic        ready;
        logic [31:0] lfsr;
        logic [4:0]  level;
    } exp_t;

    logic clk;
    logic rstN;
    int   total;
    int   bad;
    exp_t sbq[$];

    logic [31:0] m_lfsr;
    logic [4:0]  m_level;
    logic [3:0]  m_cnt;
    logic [3:0]  m_vld;
    logic [3:0]  m_approx;
    logic        m_ready;
    logic        m_reseed;
    logic [31:0] saved;

    ax_lfsr_decider_if #(.LANES(4), .LEVEL_WIDTH(5), .CNT_WIDTH(4)) bus ();

    ax_lfsr_decider #(
        .LANES(4), .LEVEL_WIDTH(5), .LFSR_WIDTH(32),
        .LFSR_SEED(SEED), .TAP_MASK(MASK), .CNT_WIDTH(4)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] galois(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr   = SEED;
        m_level  = '0;
        m_cnt    = '0;
        m_vld    = '0;
        m_approx = '0;
        m_ready  = 1'b0;
        m_reseed = 1'b0;
        sbq.delete();
    endtask

    task automatic idle_inputs();
        bus.levelWe   = 1'b0;
        bus.levelIn   = '0;
        bus.reseedReq = 1'b0;
        bus.reqValid  = '0;
        bus.stall     = 1'b0;
        bus.cntClear  = 1'b0;
    endtask

    // Predict one clock of behaviour from the current inputs, push it, clock, pop and compare.
    task automatic cyc(input string tag);
        exp_t       e;
        logic       acc;
        logic [3:0] ap;
        int         sum;
        acc = m_ready && !bus.stall && !bus.reseedReq && (bus.reqValid != 4'b0);
        for (int i = 0; i < 4; i++) begin
            ap[i] = bus.reqValid[i] && (m_lfsr[i*5 +: 5] < m_level);
        end
        if (bus.cntClear) begin
            m_cnt = '0;
        end else if (acc) begin
            sum = int'(m_cnt) + int'(ap[0]) + int'(ap[1]) + int'(ap[2]) + int'(ap[3]);
            m_cnt = (sum > 15) ? 4'd15 : sum[3:0];
        end
        if (!bus.stall) begin
            if (m_reseed) begin
                m_lfsr   = SEED;
                m_reseed = 1'b0;
                m_vld    = '0;
            end else begin
                if (m_ready && bus.reseedReq) m_reseed = 1'b1;
                m_vld = acc ? bus.reqValid : 4'b0;
                if (acc) begin
                    m_approx = ap;
                    m_lfsr   = galois(m_lfsr);
                end
            end
        end
        if (bus.levelWe) m_level = bus.levelIn;
        m_ready = !m_reseed;
        e = '{vld: m_vld, approx: m_approx, cnt: m_cnt, ready: m_ready, lfsr: m_lfsr, level: m_level};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({tag, " decValid"}, 32'(bus.decValid), 32'(e.vld));
        check({tag, " decApprox"}, 32'(bus.decApprox & bus.decValid), 32'(e.approx & e.vld));
        check({tag, " count"}, 32'(bus.approxCount), 32'(e.cnt));
        check({tag, " ready"}, 32'(bus.ready), 32'(e.ready));
        check({tag, " lfsr"}, dut.lfsr, e.lfsr);
        check({tag, " level"}, 32'(bus.level), 32'(e.level));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rst decValid"}, 32'(bus.decValid), 32'h0);
        check({tag, " rst decApprox"}, 32'(bus.decApprox), 32'h0);
        check({tag, " rst count"}, 32'(bus.approxCount), 32'h0);
        check({tag, " rst level"}, 32'(bus.level), 32'h0);
        check({tag, " rst ready"}, 32'(bus.ready), 32'h0);
        check({tag, " rst lfsr"}, dut.lfsr, SEED);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("init");
        release_reset();

        // Scenario 1: level 5, full request from the seed state.
        bus.levelWe = 1'b1; bus.levelIn = 5'd5;
        cyc("s1 level");
        idle_inputs();
        cyc("s1 idle");
        bus.reqValid = 4'b1111;
        cyc("s1 req");
        check("s1 approx const", 32'(bus.decApprox), 32'hE);
        check("s1 count const", 32'(bus.approxCount), 32'd3);
        check("s1 lfsr const", dut.lfsr, 32'h0808);

        // Scenario 2: level 0 never approximates across 100 advances.
        idle_inputs();
        bus.levelWe = 1'b1; bus.levelIn = 5'd0; bus.cntClear = 1'b1;
        cyc("s2 level");
        idle_inputs();
        cyc("s2 idle");
        bus.reqValid = 4'b1111;
        for (int i = 0; i < 100; i++) cyc("s2 run");
        check("s2 count zero", 32'(bus.approxCount), 32'd0);

        // Scenario 3: stall freezes outputs and LFSR, then one step on release.
        idle_inputs();
        bus.levelWe = 1'b1; bus.levelIn = 5'd5;
        cyc("s3 level");
        idle_inputs();
        bus.reqValid = 4'b1111;
        cyc("s3 pre");
        saved = m_lfsr;
        bus.reqValid = 4'b0101; bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("s3 stall");
        check("s3 lfsr frozen", dut.lfsr, saved);
        check("s3 vld frozen", 32'(bus.decValid), 32'hF);
        bus.stall = 1'b0;
        cyc("s3 release");
        check("s3 one step", dut.lfsr, galois(saved));
        check("s3 vld", 32'(bus.decValid), 32'h5);

        // Scenario 4: reseed beats a same-cycle request; RESEED ignores reseedReq.
        idle_inputs();
        bus.reqValid = 4'b1111;
        for (int i = 0; i < 10; i++) cyc("s4 steps");
        bus.reseedReq = 1'b1;
        cyc("s4 reseed");
        check("s4 ready low", 32'(bus.ready), 32'h0);
        check("s4 dropped", 32'(bus.decValid), 32'h0);
        bus.reqValid = 4'b0;
        cyc("s4 in reseed");
        check("s4 lfsr seed", dut.lfsr, SEED);
        check("s4 ready back", 32'(bus.ready), 32'h1);
        bus.reseedReq = 1'b0; bus.cntClear = 1'b1;
        cyc("s4 clear");
        bus.cntClear = 1'b0; bus.reqValid = 4'b1111;
        cyc("s4 repeat");
        check("s4 approx const", 32'(bus.decApprox), 32'hE);
        check("s4 lfsr const", dut.lfsr, 32'h0808);
        check("s4 count const", 32'(bus.approxCount), 32'd3);

        // Scenario 5: level 31 random traffic, counter saturation, clear priority.
        idle_inputs();
        bus.levelWe = 1'b1; bus.levelIn = 5'd31;
        cyc("s5 level");
        idle_inputs();
        for (int i = 0; i < 80; i++) begin
            bus.reqValid = 4'($urandom_range(0, 15));
            bus.stall    = ($urandom_range(0, 7) == 0);
            cyc("s5 rand");
        end
        bus.stall = 1'b0; bus.reqValid = 4'b1111;
        cyc("s5 sat");
        check("s5 saturated", 32'(bus.approxCount), 32'd15);
        bus.cntClear = 1'b1;
        cyc("s5 clear");
        check("s5 clear wins", 32'(bus.approxCount), 32'd0);
        check("s5 clear vld", 32'(bus.decValid), 32'hF);

        // Scenario 6: async reset in the middle of RESEED.
        idle_inputs();
        bus.reseedReq = 1'b1; bus.reqValid = 4'b1111;
        cyc("s6 reseed");
        bus.reseedReq = 1'b0; bus.reqValid = 4'b0;
        #3;
        rstN = 1'b0;
        #1;
        model_reset();
        check_reset_values("s6 mid-reseed");
        idle_inputs();
        release_reset();
        cyc("s6 after");

        // Scenario 7: async reset in the middle of a stall.
        bus.levelWe = 1'b1; bus.levelIn = 5'd20;
        cyc("s7 level");
        idle_inputs();
        bus.reqValid = 4'b1111;
        cyc("s7 req");
        bus.stall = 1'b1;
        cyc("s7 stall");
        #3;
        rstN = 1'b0;
        #1;
        model_reset();
        check_reset_values("s7 mid-stall");
        idle_inputs();
        release_reset();
        cyc("s7 after");
        check("s7 lfsr seed", dut.lfsr, SEED);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
